// File: rtl/seqplu_mon_if.sv
// Pulse-bus monitor interface: the generator's one-hot bus q plus the
// monitor's status outputs.
//   q        generator -> monitor   one-hot pulse bus
//   locked   monitor -> consumer    rotation is being tracked
//   phase    monitor -> consumer    index of the hot bit in the last one-hot q
//   err      monitor -> consumer    one-cycle pulse on lock loss
//   err_cnt  monitor -> consumer    saturating count of lock losses
interface seqplu_mon_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERRW  = 8
);
    localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] q;
    logic             locked;
    logic [PW-1:0]    phase;
    logic             err;
    logic [ERRW-1:0]  err_cnt;

    // Generator / stimulus side
    modport master (
        output q,
        input  locked, phase, err, err_cnt
    );

    // Monitor side
    modport slave (
        input  q,
        output locked, phase, err, err_cnt
    );
endinterface

// File: rtl/seqplu_mon.sv
// Receive-side monitor for a one-hot rotating pulse bus.
// Samples bus.q every rising clk edge, checks that it rotates left by one bit
// per cycle and reports lock status, current phase, a lock-loss pulse and a
// saturating lock-loss counter. All outputs are registered (1-cycle latency).
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   seqplu_mon_if.slave: q in; locked, phase, err, err_cnt out
module seqplu_mon #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERRW     = 8
) (
    input  logic         clk,
    input  logic         rst,
    seqplu_mon_if.slave  bus
);
    localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    good_cnt, good_cnt_d;
    logic             locked, locked_d;
    logic [PW-1:0]    phase, phase_d;
    logic             err, err_d;
    logic [ERRW-1:0]  err_cnt, err_cnt_d;

    logic             q_oh;
    logic             step;
    logic [PW-1:0]    q_idx;

    // Sample classification: one-hot check, valid rotate-left step, hot index
    always_comb begin
        q_oh  = $onehot(bus.q);
        step  = q_oh && $onehot(prev_q) &&
                (bus.q == {prev_q[WIDTH-2:0], prev_q[WIDTH-1]});
        q_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bus.q[i]) begin
                q_idx = PW'(i);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        good_cnt_d = good_cnt;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt;
        phase_d    = q_oh ? q_idx : phase;

        case (state)
            HUNT: begin
                if (q_oh) begin
                    state_d    = TRACK;
                    good_cnt_d = '0;
                end
            end
            TRACK: begin
                if (step) begin
                    if (good_cnt == CW'(LOCK_CNT - 1)) begin
                        state_d    = LOCK;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt + CW'(1);
                    end
                end else if (q_oh) begin
                    // Re-seed on a fresh one-hot value
                    good_cnt_d = '0;
                end else begin
                    state_d = HUNT;
                end
            end
            LOCK: begin
                // Any bad step, even onto a new one-hot value, drops to HUNT
                if (!step) begin
                    state_d = HUNT;
                    err_d   = 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt_d = err_cnt + ERRW'(1);
                    end
                end
            end
            default: begin
                state_d    = HUNT;
                good_cnt_d = '0;
            end
        endcase

        locked_d = (state_d == LOCK);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            prev_q   <= '0;
            good_cnt <= '0;
            locked   <= 1'b0;
            phase    <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state    <= state_d;
            prev_q   <= bus.q;
            good_cnt <= good_cnt_d;
            locked   <= locked_d;
            phase    <= phase_d;
            err      <= err_d;
            err_cnt  <= err_cnt_d;
        end
    end

    assign bus.locked  = locked;
    assign bus.phase   = phase;
    assign bus.err     = err;
    assign bus.err_cnt = err_cnt;
endmodule

// File: tb/tb_seqplu_mon.sv
// Self-checking bench for seqplu_mon: two instances (ERRW=8 and ERRW=2) see
// the same q stream. Directed table vectors, hand sequences for reset and
// async reset mid-lock, then random stimulus against a streak-based model.
module tb_seqplu_mon;
    localparam int unsigned WIDTH    = 4;
    localparam int unsigned LOCK_CNT = 4;
    localparam int unsigned ERRW0    = 8;
    localparam int unsigned ERRW1    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seqplu_mon_if #(.WIDTH(WIDTH), .ERRW(ERRW0)) bus0 ();
    seqplu_mon_if #(.WIDTH(WIDTH), .ERRW(ERRW1)) bus1 ();

    seqplu_mon #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERRW(ERRW0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );
    seqplu_mon #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERRW(ERRW1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int nvec = 0;
    int nmis = 0;

    // Reference model: streak = rotation steps since the last one-hot seed,
    // -1 while no seed exists; lock once the streak reaches LOCK_CNT.
    bit         m_locked [2];
    int         m_streak [2];
    int         m_phase  [2];
    bit         m_err    [2];
    int         m_cnt    [2];
    int         m_max    [2] = '{255, 3};
    int         m_prev;

    typedef struct {
        logic [3:0] q;
        logic       lk;
        int         ph;
        logic       er;
        int         cn;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_locked[k] = 1'b0;
            m_streak[k] = -1;
            m_phase[k]  = 0;
            m_err[k]    = 1'b0;
            m_cnt[k]    = 0;
        end
        m_prev = 0;
    endtask

    task automatic model_step(input int qv);
        bit oh;
        bit step;
        int rot;
        oh   = ($countones(qv) == 1);
        rot  = ((m_prev * 2) % 16) + (m_prev / 8);
        step = oh && ($countones(m_prev) == 1) && (qv == rot);
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 1'b0;
            if (m_locked[k]) begin
                if (!step) begin
                    m_locked[k] = 1'b0;
                    m_err[k]    = 1'b1;
                    m_cnt[k]    = (m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_max[k];
                    m_streak[k] = -1;
                end
            end else if (step && m_streak[k] >= 0) begin
                m_streak[k]++;
                if (m_streak[k] == LOCK_CNT) m_locked[k] = 1'b1;
            end else if (oh) begin
                m_streak[k] = 0;
            end else begin
                m_streak[k] = -1;
            end
            if (oh) m_phase[k] = $clog2(qv);
        end
        m_prev = qv;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".locked0"},  32'(bus0.locked),  32'(m_locked[0]));
        chk({tag, ".phase0"},   32'(bus0.phase),   32'(m_phase[0]));
        chk({tag, ".err0"},     32'(bus0.err),     32'(m_err[0]));
        chk({tag, ".err_cnt0"}, 32'(bus0.err_cnt), 32'(m_cnt[0]));
        chk({tag, ".locked1"},  32'(bus1.locked),  32'(m_locked[1]));
        chk({tag, ".phase1"},   32'(bus1.phase),   32'(m_phase[1]));
        chk({tag, ".err1"},     32'(bus1.err),     32'(m_err[1]));
        chk({tag, ".err_cnt1"}, 32'(bus1.err_cnt), 32'(m_cnt[1]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".locked0"},  32'(bus0.locked),  32'd0);
        chk({tag, ".phase0"},   32'(bus0.phase),   32'd0);
        chk({tag, ".err0"},     32'(bus0.err),     32'd0);
        chk({tag, ".err_cnt0"}, 32'(bus0.err_cnt), 32'd0);
        chk({tag, ".locked1"},  32'(bus1.locked),  32'd0);
        chk({tag, ".err_cnt1"}, 32'(bus1.err_cnt), 32'd0);
    endtask

    // Drive q on the falling edge, let the model follow the rising edge,
    // sample outputs 1 time unit later.
    task automatic tick(input logic [3:0] qv);
        @(negedge clk);
        bus0.q = qv;
        bus1.q = qv;
        @(posedge clk);
        model_step(int'(qv));
        #1;
    endtask

    task automatic addv(input logic [3:0] q, input logic lk, input int ph, input logic er, input int cn);
        vec_t v;
        v.q = q; v.lk = lk; v.ph = ph; v.er = er; v.cn = cn;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] cur;
        int         cnt_sat;

        // Directed vectors from reset: acquire, glitch, stuck, skip,
        // all-zero, lock loss onto a new one-hot value, multi-hot.
        addv(4'b0000, 0, 0, 0, 0);
        addv(4'b0001, 0, 0, 0, 0);
        addv(4'b0010, 0, 1, 0, 0);
        addv(4'b0100, 0, 2, 0, 0);
        addv(4'b1000, 0, 3, 0, 0);
        addv(4'b0001, 1, 0, 0, 0);
        addv(4'b0010, 1, 1, 0, 0);
        addv(4'b0011, 0, 1, 1, 1);
        addv(4'b0100, 0, 2, 0, 1);
        addv(4'b1000, 0, 3, 0, 1);
        addv(4'b0001, 0, 0, 0, 1);
        addv(4'b0010, 0, 1, 0, 1);
        addv(4'b0100, 1, 2, 0, 1);
        addv(4'b0100, 0, 2, 1, 2);
        addv(4'b1000, 0, 3, 0, 2);
        addv(4'b0001, 0, 0, 0, 2);
        addv(4'b0100, 0, 2, 0, 2);
        addv(4'b1000, 0, 3, 0, 2);
        addv(4'b0001, 0, 0, 0, 2);
        addv(4'b0010, 0, 1, 0, 2);
        addv(4'b0100, 1, 2, 0, 2);
        addv(4'b0000, 0, 2, 1, 3);
        addv(4'b0000, 0, 2, 0, 3);
        addv(4'b1000, 0, 3, 0, 3);
        addv(4'b0001, 0, 0, 0, 3);
        addv(4'b0010, 0, 1, 0, 3);
        addv(4'b0100, 0, 2, 0, 3);
        addv(4'b1000, 1, 3, 0, 3);
        addv(4'b0010, 0, 1, 1, 4);
        addv(4'b0100, 0, 2, 0, 4);
        addv(4'b1000, 0, 3, 0, 4);
        addv(4'b0001, 0, 0, 0, 4);
        addv(4'b0010, 0, 1, 0, 4);
        addv(4'b0100, 1, 2, 0, 4);
        addv(4'b1100, 0, 2, 1, 5);
        addv(4'b0000, 0, 2, 0, 5);

        // Reset asserted between edges while q toggles
        rst    = 1'b1;
        bus0.q = 4'b0001;
        bus1.q = 4'b0001;
        #3 rst = 1'b0;
        #1 check_zero("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus0.q = 4'(1 << (i % 4)) | 4'(i);
            bus1.q = bus0.q;
            @(posedge clk);
            #1 check_zero("reset_hold");
        end
        model_reset();

        // Release with q idle: HUNT must hold
        @(negedge clk);
        bus0.q = 4'b0000;
        bus1.q = 4'b0000;
        rst    = 1'b1;
        @(posedge clk);
        model_step(0);
        #1 check_zero("release_idle");

        // Table vectors; the ERRW=2 instance expects a saturated count
        foreach (vecs[i]) begin
            tick(vecs[i].q);
            cnt_sat = (vecs[i].cn > 3) ? 3 : vecs[i].cn;
            chk($sformatf("vec%0d.locked0", i),  32'(bus0.locked),  32'(vecs[i].lk));
            chk($sformatf("vec%0d.phase0", i),   32'(bus0.phase),   32'(vecs[i].ph));
            chk($sformatf("vec%0d.err0", i),     32'(bus0.err),     32'(vecs[i].er));
            chk($sformatf("vec%0d.err_cnt0", i), 32'(bus0.err_cnt), 32'(vecs[i].cn));
            chk($sformatf("vec%0d.err1", i),     32'(bus1.err),     32'(vecs[i].er));
            chk($sformatf("vec%0d.err_cnt1", i), 32'(bus1.err_cnt), 32'(cnt_sat));
        end

        // Async reset mid-LOCK: outputs drop before the next clock edge
        tick(4'b0000);
        tick(4'b0001);
        tick(4'b0010);
        tick(4'b0100);
        tick(4'b1000);
        tick(4'b0001);
        chk("midlock.locked0", 32'(bus0.locked), 32'd1);
        check_model("midlock");
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("midlock_rst");
        model_reset();
        @(negedge clk);
        bus0.q = 4'b0000;
        bus1.q = 4'b0000;
        rst    = 1'b1;

        // Randomised stream: mostly clean rotation with occasional faults
        cur = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($countones(cur) != 1) begin
                cur = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3))
                                                  : 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 99) < 88) begin
                cur = {cur[2:0], cur[3]};
            end else begin
                cur = 4'($urandom_range(0, 15));
            end
            tick(cur);
            check_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
